// File: rtl/n64_pi_fetch.sv
// n64_pi_fetch: turns PI read transactions into 16-bit memory fetches.
// One request may be outstanding at a time. Banks that allow read-ahead fetch
// the next word into a single buffer. A new start aborts the transaction in
// flight, and data still owed by memory to the aborted transaction is dropped.

`ifndef BANK_INVALID
`define BANK_INVALID 4'hF
`endif
`ifndef BANK_ROM
`define BANK_ROM 4'h1
`endif
`ifndef BANK_CART
`define BANK_CART 4'h2
`endif

module n64_pi_fetch (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [25:0] i_translated_address,
  input  logic [3:0]  i_bank,
  input  logic        i_bank_prefetch,
  input  logic        i_read_strobe,
  output logic        o_request,
  output logic [25:0] o_address,
  output logic [3:0]  o_bank,
  input  logic        i_ack,
  input  logic        i_data_valid,
  input  logic [15:0] i_data,
  output logic [15:0] o_data,
  output logic        o_data_valid,
  output logic        o_underrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    READY = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic [25:0] addr_q, addr_d;
  logic [3:0]  bank_q, bank_d;
  logic        pf_q, pf_d;
  logic [15:0] data_q, data_d;
  logic        dv_q, dv_d;
  logic [15:0] buf_q, buf_d;
  logic        bv_q, bv_d;
  logic        und_q, und_d;
  logic [1:0]  disc_q, disc_d;   // returns still owed to aborted transactions
  logic        accept_s;
  logic        drop_s;

  // State register with synchronous reset that overrides every other input.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= 26'd0;
      bank_q  <= `BANK_INVALID;
      pf_q    <= 1'b0;
      data_q  <= 16'd0;
      dv_q    <= 1'b0;
      buf_q   <= 16'd0;
      bv_q    <= 1'b0;
      und_q   <= 1'b0;
      disc_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      bank_q  <= bank_d;
      pf_q    <= pf_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      buf_q   <= buf_d;
      bv_q    <= bv_d;
      und_q   <= und_d;
      disc_q  <= disc_d;
    end
  end

  // Next-state logic: consume, then accept return data, then sequence, and finally handle an abort.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bank_d  = bank_q;
    pf_d    = pf_q;
    data_d  = data_q;
    dv_d    = dv_q;
    buf_d   = buf_q;
    bv_d    = bv_q;
    und_d   = 1'b0;

    // Returned data belongs to an aborted transaction first; only then to ours.
    drop_s   = i_data_valid && (disc_q != 2'd0);
    accept_s = i_data_valid && (disc_q == 2'd0) && (state_q == WAIT);
    if (drop_s) begin
      disc_d = disc_q - 2'd1;
    end else begin
      disc_d = disc_q;
    end

    // The PI bus consumes the presented word; the buffered word moves up.
    if (i_read_strobe) begin
      if (dv_q) begin
        if (bv_q) begin
          data_d = buf_q;
          bv_d   = 1'b0;
        end else begin
          dv_d = 1'b0;
        end
      end else begin
        und_d = 1'b1;
      end
    end else begin
      und_d = 1'b0;
    end

    // A fresh word goes to the bus if it is free, otherwise to the buffer.
    if (accept_s) begin
      if (!dv_d) begin
        data_d = i_data;
        dv_d   = 1'b1;
      end else begin
        buf_d = i_data;
        bv_d  = 1'b1;
      end
    end else begin
      buf_d = buf_d;
    end

    case (state_q)
      IDLE: state_d = IDLE;
      REQ: begin
        if (i_ack) begin
          addr_d  = addr_q + 26'd2;
          state_d = WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (accept_s) begin
          state_d = READY;
        end else begin
          state_d = WAIT;
        end
      end
      READY: begin
        // Read-ahead refills the empty buffer; otherwise wait for consumption.
        if (pf_q) begin
          state_d = bv_d ? READY : REQ;
        end else begin
          state_d = dv_d ? READY : REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // Start restarts from scratch. A request that was acked but has not returned is owed a discard.
    if (i_start) begin
      dv_d = 1'b0;
      bv_d = 1'b0;
      if (((state_q == REQ) && i_ack) || ((state_q == WAIT) && !accept_s)) begin
        disc_d = (disc_d == 2'd3) ? 2'd3 : disc_d + 2'd1;
      end else begin
        disc_d = disc_d;
      end
      if (i_bank != `BANK_INVALID) begin
        addr_d  = i_translated_address & 26'h3FFFFFE;
        bank_d  = i_bank;
        pf_d    = i_bank_prefetch;
        state_d = REQ;
      end else begin
        state_d = IDLE;
      end
    end else begin
      pf_d = pf_d;
    end

    req_d = (state_d == REQ);
  end

  assign o_request    = req_q;
  assign o_address    = addr_q;
  assign o_bank       = bank_q;
  assign o_data       = data_q;
  assign o_data_valid = dv_q;
  assign o_underrun   = und_q;

endmodule

// File: tb/tb_n64_pi_fetch.sv
// Self-checking bench for n64_pi_fetch: table of start vectors plus
// hand-written sequences for read-ahead, abort, underrun and reset corners.

`ifndef BANK_INVALID
`define BANK_INVALID 4'hF
`endif
`ifndef BANK_ROM
`define BANK_ROM 4'h1
`endif
`ifndef BANK_CART
`define BANK_CART 4'h2
`endif

module tb_n64_pi_fetch;

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_bank_prefetch, i_read_strobe, i_ack, i_data_valid;
  logic [25:0] i_translated_address;
  logic [3:0]  i_bank;
  logic [15:0] i_data;
  logic        o_request, o_data_valid, o_underrun;
  logic [25:0] o_address;
  logic [3:0]  o_bank;
  logic [15:0] o_data;

  int          n_vec = 0;
  int          n_bad = 0;
  int          req_count;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [25:0] addr;
    logic [3:0]  bank;
    logic [15:0] data;
    logic [25:0] exp_a0;
    logic [25:0] exp_a1;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  n64_pi_fetch dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
    .i_translated_address(i_translated_address), .i_bank(i_bank),
    .i_bank_prefetch(i_bank_prefetch), .i_read_strobe(i_read_strobe),
    .o_request(o_request), .o_address(o_address), .o_bank(o_bank),
    .i_ack(i_ack), .i_data_valid(i_data_valid), .i_data(i_data),
    .o_data(o_data), .o_data_valid(o_data_valid), .o_underrun(o_underrun)
  );

  function automatic logic [15:0] mem_word(input logic [25:0] a);
    return a[16:1] ^ 16'hC35A;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_start(input logic [25:0] a, input logic [3:0] b, input logic pf);
    i_start = 1'b1;
    i_translated_address = a;
    i_bank = b;
    i_bank_prefetch = pf;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_req(input string name, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (o_request) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk({name, " request timeout"}, 32'd0, 32'd1);
  endtask

  // Accept one request, return one word, and record the word in the scoreboard.
  task automatic serve(input string name, input logic [25:0] exp_a, input logic [15:0] dat);
    logic ok;
    wait_req(name, ok);
    if (ok) begin
      chk({name, " addr"}, 32'(o_address), 32'(exp_a));
      req_count++;
      i_ack = 1'b1;
      tick();
      i_ack = 1'b0;
      chk({name, " single outstanding"}, 32'(o_request), 32'd0);
      exp_q.push_back(dat);
      i_data_valid = 1'b1;
      i_data = dat;
      tick();
      i_data_valid = 1'b0;
      chk({name, " data valid latency"}, 32'(o_data_valid), 32'd1);
    end
  endtask

  // Check the presented word against the scoreboard, then strobe it away.
  task automatic consume(input string name);
    logic [15:0] e;
    chk({name, " valid before strobe"}, 32'(o_data_valid), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({name, " data"}, 32'(o_data), 32'(e));
    end else begin
      chk({name, " scoreboard empty"}, 32'd0, 32'd1);
    end
    i_read_strobe = 1'b1;
    tick();
    i_read_strobe = 1'b0;
    chk({name, " no underrun"}, 32'(o_underrun), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    logic        ok;
    logic [15:0] e;
    int          nreq;

    vecs[0] = '{26'h0000101, `BANK_ROM,  16'hABCD, 26'h0000100, 26'h0000102};
    vecs[1] = '{26'h3FFFFFE, `BANK_ROM,  16'h1357, 26'h3FFFFFE, 26'h0000000};
    vecs[2] = '{26'h3FFFFFF, `BANK_CART, 16'h2468, 26'h3FFFFFE, 26'h0000000};
    vecs[3] = '{26'h1234567, `BANK_CART, 16'h0F0F, 26'h1234566, 26'h1234568};
    vecs[4] = '{26'h0000000, `BANK_ROM,  16'hFFFF, 26'h0000000, 26'h0000002};

    i_reset = 1'b0; i_start = 1'b0; i_bank_prefetch = 1'b0; i_read_strobe = 1'b0;
    i_ack = 1'b0; i_data_valid = 1'b0; i_translated_address = 26'd0;
    i_bank = 4'h0; i_data = 16'd0;
    req_count = 0;

    // Reset values.
    do_reset();
    chk("reset request", 32'(o_request), 32'd0);
    chk("reset address", 32'(o_address), 32'd0);
    chk("reset bank", 32'(o_bank), 32'(`BANK_INVALID));
    chk("reset data", 32'(o_data), 32'd0);
    chk("reset data_valid", 32'(o_data_valid), 32'd0);
    chk("reset underrun", 32'(o_underrun), 32'd0);

    // Read-ahead banks: the address is aligned, data arrives, and the next word is fetched without a strobe.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      do_start(vecs[i].addr, vecs[i].bank, 1'b1);
      serve($sformatf("v%0d first", i), vecs[i].exp_a0, vecs[i].data);
      chk($sformatf("v%0d bank", i), 32'(o_bank), 32'(vecs[i].bank));
      e = exp_q.pop_front();
      chk($sformatf("v%0d o_data", i), 32'(o_data), 32'(e));
      wait_req($sformatf("v%0d readahead", i), ok);
      if (ok) chk($sformatf("v%0d readahead addr", i), 32'(o_address), 32'(vecs[i].exp_a1));
    end

    // Invalid bank start: no request and no data.
    do_reset();
    do_start(26'h0000010, `BANK_INVALID, 1'b1);
    chk("invalid start request", 32'(o_request), 32'd0);
    tick(); tick();
    chk("invalid start still idle", 32'(o_request), 32'd0);
    chk("invalid start data_valid", 32'(o_data_valid), 32'd0);

    // No read-ahead: one request per consumed word.
    do_reset();
    req_count = 0;
    do_start(26'h0000000, `BANK_CART, 1'b0);
    serve("cart w0", 26'h0000000, mem_word(26'h0000000));
    nreq = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (o_request) nreq++;
    end
    chk("cart no readahead", 32'(nreq), 32'd0);
    consume("cart c0");
    serve("cart w1", 26'h0000002, mem_word(26'h0000002));
    consume("cart c1");
    serve("cart w2", 26'h0000004, mem_word(26'h0000004));
    chk("cart requests before third strobe", 32'(req_count), 32'd3);
    consume("cart c2");
    chk("cart emptied", 32'(o_data_valid), 32'd0);

    // Strobe with nothing presented: one-cycle underrun and no other state change.
    i_read_strobe = 1'b1;
    tick();
    i_read_strobe = 1'b0;
    chk("underrun pulse", 32'(o_underrun), 32'd1);
    chk("underrun data_valid", 32'(o_data_valid), 32'd0);
    chk("underrun request held", 32'(o_request), 32'd1);
    chk("underrun address held", 32'(o_address), 32'h0000006);
    tick();
    chk("underrun one cycle", 32'(o_underrun), 32'd0);

    // Data and strobe arrive in the same cycle with the bus empty: report an underrun and load the data.
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    i_data_valid = 1'b1; i_data = mem_word(26'h0000006); i_read_strobe = 1'b1;
    tick();
    i_data_valid = 1'b0; i_read_strobe = 1'b0;
    chk("strobe+data underrun", 32'(o_underrun), 32'd1);
    chk("strobe+data valid", 32'(o_data_valid), 32'd1);
    chk("strobe+data word", 32'(o_data), 32'(mem_word(26'h0000006)));

    // Abort during WAIT: the stale return is dropped and only the new word is shown.
    do_reset();
    do_start(26'h0000200, `BANK_ROM, 1'b1);
    wait_req("abort first", ok);
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    do_start(26'h0000401, `BANK_ROM, 1'b0);
    chk("abort restart request", 32'(o_request), 32'd1);
    chk("abort restart address", 32'(o_address), 32'h0000400);
    chk("abort cleared valid", 32'(o_data_valid), 32'd0);
    i_data_valid = 1'b1; i_data = 16'h1111;
    tick();
    i_data_valid = 1'b0;
    chk("stale dropped", 32'(o_data_valid), 32'd0);
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    i_data_valid = 1'b1; i_data = 16'h2222;
    tick();
    i_data_valid = 1'b0;
    chk("new word valid", 32'(o_data_valid), 32'd1);
    chk("new word data", 32'(o_data), 32'h2222);
    i_data_valid = 1'b1; i_data = 16'h3333;
    tick();
    i_data_valid = 1'b0;
    chk("unsolicited data ignored", 32'(o_data), 32'h2222);
    do_start(26'h0000000, `BANK_INVALID, 1'b1);
    chk("invalid abort clears valid", 32'(o_data_valid), 32'd0);
    chk("invalid abort no request", 32'(o_request), 32'd0);

    // Reset in WAIT overrides a same-cycle return and start; a late return is ignored.
    do_reset();
    do_start(26'h0000080, `BANK_ROM, 1'b1);
    wait_req("reset-wait", ok);
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    i_reset = 1'b1; i_data_valid = 1'b1; i_data = 16'h5555;
    i_start = 1'b1; i_translated_address = 26'h0000100; i_bank = `BANK_ROM;
    tick();
    i_reset = 1'b0; i_data_valid = 1'b0; i_start = 1'b0;
    chk("rst-wait request", 32'(o_request), 32'd0);
    chk("rst-wait address", 32'(o_address), 32'd0);
    chk("rst-wait bank", 32'(o_bank), 32'(`BANK_INVALID));
    chk("rst-wait data", 32'(o_data), 32'd0);
    chk("rst-wait valid", 32'(o_data_valid), 32'd0);
    chk("rst-wait underrun", 32'(o_underrun), 32'd0);
    i_data_valid = 1'b1; i_data = 16'h6666;
    tick();
    i_data_valid = 1'b0;
    chk("late data ignored valid", 32'(o_data_valid), 32'd0);
    chk("late data ignored word", 32'(o_data), 32'd0);
    chk("late data no request", 32'(o_request), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
